cond_mc_ctrl: RTL and testbench

Multicycle sequencer for the processor core's conditional-execution path. Walks each instruction through fetch/decode/execute/memory/writeback states and owns the architectural NZCV flag register. Evaluates the 3-bit condition field against the stored flags in DECODE and drives the datapath strobes. Sits between the instruction register fields and the datapath/memory port, and waits on a memory ready handshake.

---
 rtl/cond_mc_if.sv | 36 +++
 rtl/cond_mc_ctrl.sv | 158 +++++++++++++++
 tb/tb_cond_mc_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_mc_if.sv
// Bundle between the conditional-execution sequencer and its datapath/memory side.
// master = sequencer, slave = datapath, instruction register and memory port.
interface cond_mc_if;
    logic [2:0]  cond;
    logic [1:0]  op;
    logic        s_l;
    logic [3:0]  alu_flags;
    logic        mem_rdy;

    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [3:0]  flags_q;
    logic        illegal;
    logic [15:0] retired_cnt;
    logic [15:0] skipped_cnt;

    modport master (
        input  cond, op, s_l, alu_flags, mem_rdy,
        output mem_req, mem_write, adr_src, alu_src_b, result_src,
               ir_write, pc_write, reg_write, flags_q, illegal,
               retired_cnt, skipped_cnt
    );

    modport slave (
        output cond, op, s_l, alu_flags, mem_rdy,
        input  mem_req, mem_write, adr_src, alu_src_b, result_src,
               ir_write, pc_write, reg_write, flags_q, illegal,
               retired_cnt, skipped_cnt
    );
endinterface

// File: rtl/cond_mc_ctrl.sv
// Multicycle sequencer for conditionally executed instructions; owns the NZCV
// flag register and the retired/skipped instruction counters.
module cond_mc_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    cond_mc_if.master     bus
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEM_RD  = 4'd3;
    localparam logic [3:0] S_MEM_WR  = 4'd4;
    localparam logic [3:0] S_EXEC_DP = 4'd5;
    localparam logic [3:0] S_WB_ALU  = 4'd6;
    localparam logic [3:0] S_WB_MEM  = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] retired_cnt_q, retired_cnt_d;
    logic [15:0] skipped_cnt_q, skipped_cnt_d;

    logic cond_ok;
    logic cond_defined;
    logic illegal_insn;
    logic retire;
    logic skip;

    logic flag_n, flag_z, flag_v;
    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_v = flags_q[0];

    // Condition is judged against the stored flags, never the live ALU flags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cond_ok      = 1'b0;
        cond_defined = 1'b1;
        case (bus.cond)
            3'b000:  cond_ok = flag_z;
            3'b001:  cond_ok = flag_n;
            3'b010:  cond_ok = ~flag_z & (flag_n == flag_v);
            3'b111:  cond_ok = 1'b1;
            default: cond_defined = 1'b0;
        endcase
    end

    assign illegal_insn = ~cond_defined | (bus.op == 2'b11);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (bus.mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                if (illegal_insn || !cond_ok) begin
                    state_d = S_FETCH;
                end else begin
                    case (bus.op)
                        2'b00:   state_d = S_EXEC_DP;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC_DP: state_d = S_WB_ALU;
            S_WB_ALU:  state_d = S_FETCH;
            S_MEMADR:  state_d = bus.s_l ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (bus.mem_rdy) state_d = S_WB_MEM;
            S_WB_MEM:  state_d = S_FETCH;
            S_MEM_WR:  if (bus.mem_rdy) state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    assign retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                    (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WR) && bus.mem_rdy);
    assign skip   = (state_q == S_DECODE) && (illegal_insn || !cond_ok);

    always_comb begin
        flags_d = flags_q;
        if (state_q == S_EXEC_DP && bus.s_l) flags_d = bus.alu_flags;
    end

    // Retire and skip are mutually exclusive by state, so the counters never race.
    assign retired_cnt_d = retired_cnt_q + {15'd0, retire};
    assign skipped_cnt_d = skipped_cnt_q + {15'd0, skip};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            flags_q       <= 4'd0;
            retired_cnt_q <= 16'd0;
            skipped_cnt_q <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            flags_q       <= flags_d;
            retired_cnt_q <= retired_cnt_d;
            skipped_cnt_q <= skipped_cnt_d;
        end
    end

    // Strobes are qualified by rst_n so a pending request drops the instant reset asserts.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req    = rst_n;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = rst_n & bus.mem_rdy;
                bus.pc_write   = rst_n & bus.mem_rdy;
            end
            S_DECODE:  bus.illegal = rst_n & illegal_insn;
            S_MEMADR:  bus.alu_src_b = 2'b01;
            S_MEM_RD: begin
                bus.mem_req = rst_n;
                bus.adr_src = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req   = rst_n;
                bus.mem_write = rst_n;
                bus.adr_src   = 1'b1;
            end
            S_WB_ALU: begin
                bus.reg_write  = rst_n;
                bus.result_src = 2'b00;
            end
            S_WB_MEM: begin
                bus.reg_write  = rst_n;
                bus.result_src = 2'b01;
            end
            S_BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_write   = rst_n;
            end
            default: ;
        endcase
    end

    assign bus.flags_q     = flags_q;
    assign bus.retired_cnt = retired_cnt_q;
    assign bus.skipped_cnt = skipped_cnt_q;

endmodule

// File: tb/tb_cond_mc_ctrl.sv
// Scoreboard bench for cond_mc_ctrl: per-cycle expected strobes are queued with
// each instruction and compared at the falling edge as the sequencer runs.
module tb_cond_mc_ctrl;

    typedef enum {K_DP, K_LD, K_ST, K_BR, K_SQ, K_ILL} kind_e;

    // {mem_req, mem_write, adr_src, alu_src_b, result_src, ir_write, pc_write, reg_write, illegal}
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       illegal;
    } strobe_t;

    typedef struct {
        string   tag;
        logic    rdy;
        strobe_t exp;
    } step_t;

    localparam strobe_t ST_F_RDY  = 11'b1_0_0_10_10_1_1_0_0;
    localparam strobe_t ST_F_WAIT = 11'b1_0_0_10_10_0_0_0_0;
    localparam strobe_t ST_QUIET  = 11'b0_0_0_00_00_0_0_0_0;
    localparam strobe_t ST_D_ILL  = 11'b0_0_0_00_00_0_0_0_1;
    localparam strobe_t ST_W_ALU  = 11'b0_0_0_00_00_0_0_1_0;
    localparam strobe_t ST_MADR   = 11'b0_0_0_01_00_0_0_0_0;
    localparam strobe_t ST_MRD    = 11'b1_0_1_00_00_0_0_0_0;
    localparam strobe_t ST_WB_MEM = 11'b0_0_0_00_01_0_0_1_0;
    localparam strobe_t ST_MWR    = 11'b1_1_1_00_00_0_0_0_0;
    localparam strobe_t ST_BR     = 11'b0_0_0_01_10_0_1_0_0;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] exp_retired = 16'd0;
    logic [15:0] exp_skipped = 16'd0;
    logic [3:0]  exp_flags   = 4'd0;
    step_t       sb[$];

    cond_mc_if bus();

    cond_mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic strobe_t sample();
        strobe_t s;
        s.mem_req    = bus.mem_req;
        s.mem_write  = bus.mem_write;
        s.adr_src    = bus.adr_src;
        s.alu_src_b  = bus.alu_src_b;
        s.result_src = bus.result_src;
        s.ir_write   = bus.ir_write;
        s.pc_write   = bus.pc_write;
        s.reg_write  = bus.reg_write;
        s.illegal    = bus.illegal;
        return s;
    endfunction

    function automatic void push(input string tag, input logic rdy, input strobe_t e);
        step_t s;
        s.tag = tag;
        s.rdy = rdy;
        s.exp = e;
        sb.push_back(s);
    endfunction

    // Expected per-cycle strobes for one instruction, from the state output table.
    function automatic void push_insn(input string name, input kind_e kind,
                                      input int fwait, input int mwait);
        for (int i = 0; i < fwait; i++) push({name, "/fetch_wait"}, 1'b0, ST_F_WAIT);
        push({name, "/fetch"}, 1'b1, ST_F_RDY);
        case (kind)
            K_ILL: push({name, "/decode"}, 1'b1, ST_D_ILL);
            default: push({name, "/decode"}, 1'b1, ST_QUIET);
        endcase
        case (kind)
            K_DP: begin
                push({name, "/exec"}, 1'b1, ST_QUIET);
                push({name, "/wb_alu"}, 1'b1, ST_W_ALU);
            end
            K_BR: push({name, "/branch"}, 1'b1, ST_BR);
            K_LD: begin
                push({name, "/memadr"}, 1'b1, ST_MADR);
                for (int i = 0; i < mwait; i++) push({name, "/mem_rd_wait"}, 1'b0, ST_MRD);
                push({name, "/mem_rd"}, 1'b1, ST_MRD);
                push({name, "/wb_mem"}, 1'b1, ST_WB_MEM);
            end
            K_ST: begin
                push({name, "/memadr"}, 1'b1, ST_MADR);
                for (int i = 0; i < mwait; i++) push({name, "/mem_wr_wait"}, 1'b0, ST_MWR);
                push({name, "/mem_wr"}, 1'b1, ST_MWR);
            end
            default: ;
        endcase
    endfunction

    // Consume the scoreboard one clock per entry; called at posedge+1.
    task automatic drain_sb();
        while (sb.size() > 0) begin
            step_t s;
            strobe_t got;
            s = sb.pop_front();
            bus.mem_rdy = s.rdy;
            @(negedge clk);
            got = sample();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("FAIL %s strobes got %b expected %b", s.tag, got, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_insn(input string name, input kind_e kind, input logic [2:0] c,
                            input logic [1:0] o, input logic sl, input logic [3:0] af,
                            input int fwait, input int mwait);
        bus.cond      = c;
        bus.op        = o;
        bus.s_l       = sl;
        bus.alu_flags = af;
        push_insn(name, kind, fwait, mwait);
        drain_sb();
        case (kind)
            K_SQ, K_ILL: exp_skipped = exp_skipped + 16'd1;
            default:     exp_retired = exp_retired + 16'd1;
        endcase
        if (kind == K_DP && sl) exp_flags = af;
        checks++;
        if (bus.retired_cnt !== exp_retired) begin
            errors++;
            $display("FAIL %s retired_cnt got %h expected %h", name, bus.retired_cnt, exp_retired);
        end
        checks++;
        if (bus.skipped_cnt !== exp_skipped) begin
            errors++;
            $display("FAIL %s skipped_cnt got %h expected %h", name, bus.skipped_cnt, exp_skipped);
        end
        checks++;
        if (bus.flags_q !== exp_flags) begin
            errors++;
            $display("FAIL %s flags_q got %b expected %b", name, bus.flags_q, exp_flags);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.cond      = 3'b111;
        bus.op        = 2'b00;
        bus.s_l       = 1'b0;
        bus.alu_flags = 4'b0000;
        bus.mem_rdy   = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write, bus.illegal} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b expected 000000",
                     {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write, bus.illegal});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.retired_cnt, bus.skipped_cnt, bus.flags_q} !== 36'd0) begin
            errors++;
            $display("FAIL reset_state got %h/%h/%b expected 0000/0000/0000",
                     bus.retired_cnt, bus.skipped_cnt, bus.flags_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_dp();
        run_insn("dp_al_s", K_DP, 3'b111, 2'b00, 1'b1, 4'b0100, 0, 0);
    endtask

    task automatic test_branch();
        run_insn("br_eq_taken", K_BR, 3'b000, 2'b10, 1'b0, 4'b0000, 0, 0);
        run_insn("br_mi_squash", K_SQ, 3'b001, 2'b10, 1'b0, 4'b0000, 0, 0);
    endtask

    task automatic test_gt();
        run_insn("dp_set_1001", K_DP, 3'b111, 2'b00, 1'b1, 4'b1001, 0, 0);
        run_insn("br_gt_taken", K_BR, 3'b010, 2'b10, 1'b0, 4'b0000, 0, 0);
        run_insn("dp_set_1000", K_DP, 3'b111, 2'b00, 1'b1, 4'b1000, 0, 0);
        run_insn("dp_gt_squash", K_SQ, 3'b010, 2'b00, 1'b1, 4'b0110, 0, 0);
        run_insn("dp_no_s", K_DP, 3'b111, 2'b00, 1'b0, 4'b1111, 0, 0);
    endtask

    task automatic test_memory();
        run_insn("load_wait3", K_LD, 3'b111, 2'b01, 1'b1, 4'b0000, 0, 3);
        run_insn("store_fwait2", K_ST, 3'b001, 2'b01, 1'b0, 4'b0000, 2, 1);
    endtask

    task automatic test_illegal();
        run_insn("cond_011", K_ILL, 3'b011, 2'b00, 1'b1, 4'b1111, 0, 0);
        run_insn("op_11", K_ILL, 3'b111, 2'b11, 1'b1, 4'b1111, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_insn("b2b_store", K_ST, 3'b111, 2'b01, 1'b0, 4'b0000, 0, 0);
        run_insn("b2b_load", K_LD, 3'b111, 2'b01, 1'b1, 4'b0000, 0, 0);
        run_insn("b2b_branch", K_BR, 3'b111, 2'b10, 1'b0, 4'b0000, 0, 0);
    endtask

    task automatic test_reset_mid_store();
        bus.cond      = 3'b111;
        bus.op        = 2'b01;
        bus.s_l       = 1'b0;
        bus.alu_flags = 4'b0000;
        push("rst_store/fetch", 1'b1, ST_F_RDY);
        push("rst_store/decode", 1'b1, ST_QUIET);
        push("rst_store/memadr", 1'b1, ST_MADR);
        drain_sb();
        bus.mem_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_write} !== 2'b11) begin
            errors++;
            $display("FAIL rst_store/mem_wr got %b expected 11", {bus.mem_req, bus.mem_write});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_write} !== 2'b00) begin
            errors++;
            $display("FAIL rst_store/async_drop got %b expected 00", {bus.mem_req, bus.mem_write});
        end
        checks++;
        if ({bus.retired_cnt, bus.skipped_cnt, bus.flags_q} !== 36'd0) begin
            errors++;
            $display("FAIL rst_store/async_clear got %h/%h/%b expected 0000/0000/0000",
                     bus.retired_cnt, bus.skipped_cnt, bus.flags_q);
        end
        exp_retired = 16'd0;
        exp_skipped = 16'd0;
        exp_flags   = 4'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_insn("after_rst_dp", K_DP, 3'b111, 2'b00, 1'b1, 4'b0010, 0, 0);
    endtask

    task automatic test_wrap();
        bus.mem_rdy = 1'b0;
        force dut.retired_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.retired_cnt_q;
        exp_retired = 16'hFFFF;
        checks++;
        if (bus.retired_cnt !== exp_retired) begin
            errors++;
            $display("FAIL wrap_preload retired_cnt got %h expected %h", bus.retired_cnt, exp_retired);
        end
        run_insn("wrap_branch", K_BR, 3'b111, 2'b10, 1'b0, 4'b0000, 0, 0);
    endtask

    initial begin
        test_reset();
        test_dp();
        test_branch();
        test_gt();
        test_memory();
        test_illegal();
        test_back_to_back();
        test_reset_mid_store();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
